// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: instruction-memory read port, execute/decode controls,
// and the IF/ID pipeline register outputs.
interface inst_fetch_if #(
  parameter int PC_WIDTH   = 10,
  parameter int INST_WIDTH = 16
);
  logic [PC_WIDTH-1:0]   imem_addr;
  logic                  imem_rd_en;
  logic [INST_WIDTH-1:0] imem_rdata;
  logic                  stall;
  logic                  redirect;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic [INST_WIDTH-1:0] id_inst;
  logic [PC_WIDTH-1:0]   id_pc;
  logic                  id_valid;
  logic                  halted;

  modport master (
    output imem_addr, imem_rd_en, id_inst, id_pc, id_valid, halted,
    input  imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_addr, imem_rd_en, id_inst, id_pc, id_valid, halted,
    output imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, reads synchronous instruction memory,
// loads IF/ID, and handles stall, redirect and OP_HALT.
module inst_fetch #(
  parameter int PC_WIDTH     = 10,
  parameter int INST_WIDTH   = 16,
  parameter int OPCODE_WIDTH = 7,
  parameter int HALT_OPCODE  = 127
) (
  input  logic        clk,
  input  logic        rst_n,
  inst_fetch_if.master bus
);

  logic [PC_WIDTH-1:0]   pc_q;
  logic [PC_WIDTH-1:0]   f_pc_q;
  logic                  f_valid_q;
  logic [INST_WIDTH-1:0] id_inst_q;
  logic [PC_WIDTH-1:0]   id_pc_q;
  logic                  id_valid_q;
  logic                  halted_q;

  logic advance;
  logic halt_hit;

  assign advance  = !bus.redirect && !bus.stall && !halted_q;
  assign halt_hit = f_valid_q &&
                    (bus.imem_rdata[INST_WIDTH-1 -: OPCODE_WIDTH] == OPCODE_WIDTH'(HALT_OPCODE));

  // A read is issued exactly when the PC advances, so a stalled in-flight
  // read keeps its data on imem_rdata.
  assign bus.imem_rd_en = advance;
  assign bus.imem_addr  = pc_q;
  assign bus.id_inst    = id_inst_q;
  assign bus.id_pc      = id_pc_q;
  assign bus.id_valid   = id_valid_q;
  assign bus.halted     = halted_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  // NOTE: every register here is control/pipeline state and gets an async
  // reset value; there is no memory array in this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      f_pc_q     <= '0;
      f_valid_q  <= 1'b0;
      id_inst_q  <= '0;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else if (bus.redirect) begin
      // Redirect beats stall and halt: everything in flight is wrong-path.
      pc_q       <= bus.redirect_pc;
      f_valid_q  <= 1'b0;
      id_valid_q <= 1'b0;
      id_inst_q  <= '0;
      halted_q   <= 1'b0;
    end else if (bus.stall) begin
      // hold every register
    end else if (halted_q) begin
      id_valid_q <= 1'b0;
      id_inst_q  <= '0;
    end else begin
      id_valid_q <= f_valid_q;
      id_pc_q    <= f_pc_q;
      id_inst_q  <= f_valid_q ? bus.imem_rdata : '0;
      if (halt_hit) begin
        // HALT still reaches ID; the read issued behind it is dropped and
        // pc_q stays at halt address + 1.
        halted_q  <= 1'b1;
        f_valid_q <= 1'b0;
      end else begin
        pc_q      <= pc_q + PC_WIDTH'(1);
        f_pc_q    <= pc_q;
        f_valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the pipelined CPU. It owns the program counter, issues reads to the synchronous instruction memory, and loads the IF/ID pipeline register consumed by the decode stage. It also handles decode stalls, taken-branch/jump redirects from execute, and stopping fetch on OP_HALT. Bubbles are delivered to decode as valid=0 with an all-zero (OP_NOP) instruction word.

## Interface
Parameters:
- PC_WIDTH, 10, program counter / instruction memory address width (INST_MEM_SIZE = 1024)
- INST_WIDTH, 16, instruction word width (CPU_INST_WIDTH)
- OPCODE_WIDTH, 7, opcode field width; the opcode is inst[INST_WIDTH-1 -: OPCODE_WIDTH]
- HALT_OPCODE, 127, opcode value of OP_HALT

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_addr  out  PC_WIDTH  read address; equals pc_q
- imem_rd_en  out  1  read enable; the memory samples imem_addr on the edge when this is 1. imem_rdata is valid the following cycle and holds while this is 0.
- imem_rdata  in  INST_WIDTH  instruction returned by memory
- stall  in  1  decode cannot accept; hold all state
- redirect  in  1  taken branch/jump from execute; flush in-flight instructions
- redirect_pc  in  PC_WIDTH  redirect target, qualified by redirect
- id_inst  out  INST_WIDTH  IF/ID instruction; 0 whenever id_valid=0
- id_pc  out  PC_WIDTH  address of id_inst
- id_valid  out  1  id_inst is a real instruction
- halted  out  1  fetch stopped by OP_HALT

## Operation
- State: pc_q (next address to issue), f_pc_q/f_valid_q (the read in flight, whose data is on imem_rdata this cycle), id_inst_q/id_pc_q/id_valid_q, halted_q.
- imem_rd_en = !stall && !redirect && !halted_q.
- Advance (no redirect, no stall, not halted):
  - pc_q <= pc_q+1, modulo 2^PC_WIDTH, so 1023 wraps to 0.
  - f_pc_q <= pc_q; f_valid_q <= 1.
  - id_valid_q <= f_valid_q; id_pc_q <= f_pc_q; id_inst_q <= f_valid_q ? imem_rdata : 0.
- Halt detect: on an advance where f_valid_q=1 and the opcode of imem_rdata is HALT_OPCODE:
  - the HALT word still passes to ID;
  - halted_q <= 1 and f_valid_q <= 0;
  - pc_q holds at halt address+1.
- Halted (no redirect):
  - pc_q and f_* hold; no reads are issued.
  - id_valid_q <= 0 and id_inst_q <= 0 on each edge unless stall=1, in which case ID holds.
- Stall (no redirect): every register holds; no read is issued, so imem_rdata stays valid for the in-flight fetch.
- Redirect, which has priority over stall and halt:
  - pc_q <= redirect_pc.
  - f_valid_q <= 0, id_valid_q <= 0, id_inst_q <= 0.
  - halted_q <= 0, because a HALT fetched behind a taken branch is wrong-path.
- Only redirect leaves halted state; reset also clears it.

## Timing
- Reset values (async, immediate): pc_q=0, f_pc_q=0, f_valid_q=0, id_inst=0, id_pc=0, id_valid=0, halted=0, imem_addr=0.
- After rst_n rises:
  - cycle 1: issue address 0;
  - cycle 2: data on imem_rdata;
  - cycle 3: id_valid=1, id_pc=0.
- Steady state throughput: one instruction per cycle; consecutive id_pc values increment by 1.
- Redirect latency: redirect in cycle n gives id_valid=1 with id_pc=redirect_pc in cycle n+3. id_valid=0 in cycles n+1 and n+2.
- Stall: stall high for k cycles extends the current id_* contents by exactly k cycles, with no instruction lost or duplicated.
- halted rises in the cycle after the HALT word is captured into ID, which is the same cycle id_valid shows the HALT.
- Reset mid-operation: all state returns to reset values immediately; any read in flight is discarded.

## Test plan
- Reset release with imem[i]=16'h1000+i: id_pc sequence 0,1,2,… from cycle 3 with id_inst = 16'h1000+id_pc, id_valid continuously 1.
- Stall for 3 cycles while id_pc=5: id_pc=5 for 4 cycles total, then 6,7 with no gap; imem_rd_en=0 during the stall.
- redirect=1, redirect_pc=200 while stall=1 at id_pc=10: exactly 2 bubbles (id_valid=0, id_inst=0), then id_pc=200,201.
- imem[7] holds an instruction with opcode 127: id_inst shows HALT with id_pc=7; halted=1 from that cycle; id_valid=0 afterwards; imem_rd_en stays 0; a later redirect to 0 clears halted and fetch restarts at 0.
- Start at redirect_pc=1022: id_pc sequence 1022, 1023, 0, 1.
- Assert rst_n=0 mid-stream at id_pc=40: all outputs are at reset values in the same cycle; after release, fetch resumes from 0.
